// File: rtl/prbs7_tx_gen.sv
// PRBS7 (x^7+x^6+1) word source with masked user-data overlay and programmable error injection.
// One 64-bit word per enabled cycle, registered (1-cycle latency); no backpressure, enable gates progress.
module prbs7_tx_gen #(
    parameter int         PERIOD_W     = 16,
    parameter logic [6:0] SEED_DEFAULT = 7'h7F
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [6:0]          seed,
    input  logic [15:0]         mask,
    input  logic [7:0]          userData,
    input  logic [1:0]          inj_mode,
    input  logic                inj_trig,
    input  logic [63:0]         inj_pattern,
    input  logic [PERIOD_W-1:0] inj_period,
    input  logic [PERIOD_W-1:0] inj_burst,
    output logic [63:0]         dout,
    output logic                dout_valid,
    output logic                inj_active,
    output logic [PERIOD_W-1:0] inj_total
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BURST,
        ST_PERIODIC
    } inj_state_t;

    localparam logic [1:0] MODE_SINGLE   = 2'd1;
    localparam logic [1:0] MODE_PERIODIC = 2'd2;
    localparam logic [1:0] MODE_BURST    = 2'd3;

    logic [6:0]          lfsr_q, lfsr_d;
    logic [63:0]         dout_q, dout_d;
    logic                dout_valid_q, dout_valid_d;
    logic                inj_active_q, inj_active_d;
    logic [PERIOD_W-1:0] inj_total_q, inj_total_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    inj_state_t          state_q, state_d;
    logic                trig_q, trig_d;
    logic [1:0]          mode_q, mode_d;

    logic                word_en;
    logic                trig_edge;
    logic                inject;
    logic [70:0]         step_res;
    logic [63:0]         mask_w;
    logic [63:0]         word_w;

    // Returns {next_state[6:0], word[63:0]}; word bit k is the (k+1)-th serial output.
    function automatic logic [70:0] prbs_step64(input logic [6:0] st);
        logic [6:0]  s;
        logic [63:0] w;
        logic        b;
        s = st;
        w = '0;
        for (int k = 0; k < 64; k++) begin
            b    = s[6] ^ s[5];
            s    = {s[5:0], b};
            w[k] = b;
        end
        return {s, w};
    endfunction

    always_comb begin
        lfsr_d       = lfsr_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        inj_active_d = 1'b0;
        inj_total_d  = inj_total_q;
        cnt_d        = cnt_q;
        state_d      = state_q;
        trig_d       = inj_trig;
        mode_d       = inj_mode;
        inject       = 1'b0;

        word_en   = enable & ~seed_load;
        trig_edge = inj_trig & ~trig_q;
        step_res  = prbs_step64(lfsr_q);
        mask_w    = {4{mask}};
        word_w    = (step_res[63:0] & ~mask_w) | ({8{userData}} & mask_w);

        // A mode change always drops back to IDLE and aborts whatever was in progress.
        if (inj_mode != mode_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (inj_mode == MODE_PERIODIC)
                        state_d = ST_PERIODIC;
                    else if ((inj_mode == MODE_SINGLE || inj_mode == MODE_BURST) && trig_edge)
                        state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (word_en) begin
                        inject = 1'b1;
                        if (inj_mode == MODE_BURST && inj_burst != '0) begin
                            state_d = ST_BURST;
                            cnt_d   = {{(PERIOD_W-1){1'b0}}, 1'b1};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_BURST: begin
                    if (word_en) begin
                        inject = 1'b1;
                        if (cnt_q >= inj_burst) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_PERIODIC: begin
                    if (word_en) begin
                        inject = (cnt_q == '0);
                        cnt_d  = (cnt_q >= inj_period) ? '0 : cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (seed_load) begin
            lfsr_d = (seed == 7'h00) ? 7'h01 : seed;
        end else if (word_en) begin
            lfsr_d       = step_res[70:64];
            dout_d       = inject ? (word_w ^ inj_pattern) : word_w;
            dout_valid_d = 1'b1;
            inj_active_d = inject;
            if (inject && inj_total_q != '1)
                inj_total_d = inj_total_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q       <= SEED_DEFAULT;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            inj_active_q <= 1'b0;
            inj_total_q  <= '0;
            cnt_q        <= '0;
            state_q      <= ST_IDLE;
            trig_q       <= 1'b0;
            mode_q       <= 2'd0;
        end else begin
            lfsr_q       <= lfsr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            inj_active_q <= inj_active_d;
            inj_total_q  <= inj_total_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            trig_q       <= trig_d;
            mode_q       <= mode_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign inj_active = inj_active_q;
    assign inj_total  = inj_total_q;

endmodule

// File: tb/tb_prbs7_tx_gen.sv
// Scoreboard bench for prbs7_tx_gen: stimulus pushes expected words, a negedge monitor pops and compares.
module tb_prbs7_tx_gen;

    localparam int PW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          seed_load;
    logic [6:0]    seed;
    logic [15:0]   mask;
    logic [7:0]    user_data;
    logic [1:0]    inj_mode;
    logic          inj_trig;
    logic [63:0]   inj_pattern;
    logic [PW-1:0] inj_period;
    logic [PW-1:0] inj_burst;
    logic [63:0]   dout;
    logic          dout_valid;
    logic          inj_active;
    logic [PW-1:0] inj_total;

    prbs7_tx_gen #(.PERIOD_W(PW), .SEED_DEFAULT(7'h7F)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .seed_load  (seed_load),
        .seed       (seed),
        .mask       (mask),
        .userData   (user_data),
        .inj_mode   (inj_mode),
        .inj_trig   (inj_trig),
        .inj_pattern(inj_pattern),
        .inj_period (inj_period),
        .inj_burst  (inj_burst),
        .dout       (dout),
        .dout_valid (dout_valid),
        .inj_active (inj_active),
        .inj_total  (inj_total)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic        a;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   seq[127];
    int   pos;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Reference bit stream: one full 127-bit period from the given starting state.
    task automatic gen_seq(input logic [6:0] st);
        logic [6:0] s;
        logic       b;
        s = st;
        for (int i = 0; i < 127; i++) begin
            b      = s[6] ^ s[5];
            s      = {s[5:0], b};
            seq[i] = b;
        end
        pos = 0;
    endtask

    task automatic word(input logic inj_exp, input logic use_const, input logic [63:0] cval);
        logic [63:0] raw, m, w;
        for (int k = 0; k < 64; k++) raw[k] = seq[(pos + k) % 127];
        pos = (pos + 64) % 127;
        m = {4{mask}};
        w = (raw & ~m) | ({8{user_data}} & m);
        if (use_const) w = cval;
        if (inj_exp) w = w ^ inj_pattern;
        exp_q.push_back(exp_t'{d: w, a: inj_exp});
        enable = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        enable = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic load_seed(input logic [6:0] sd);
        seed      = sd;
        seed_load = 1'b1;
        enable    = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
        enable    = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        reset  = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        #1;
        chk({tag, "_dout"},       dout, 64'h0);
        chk({tag, "_dout_valid"}, {63'h0, dout_valid}, 64'h0);
        chk({tag, "_inj_active"}, {63'h0, inj_active}, 64'h0);
        chk({tag, "_inj_total"},  {48'h0, inj_total}, 64'h0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Monitor: every valid output word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && dout_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", dout, 64'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", dout, e.d);
                chk("inj_active", {63'h0, inj_active}, {63'h0, e.a});
            end
        end
    end

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        seed_load   = 1'b0;
        seed        = 7'h00;
        mask        = 16'h0;
        user_data   = 8'h00;
        inj_mode    = 2'd0;
        inj_trig    = 1'b0;
        inj_pattern = 64'h0;
        inj_period  = '0;
        inj_burst   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dout",       dout, 64'h0);
        chk("rst_dout_valid", {63'h0, dout_valid}, 64'h0);
        chk("rst_inj_total",  {48'h0, inj_total}, 64'h0);
        reset = 1'b0;

        // Plain PRBS from 7F across more than one 127-word period.
        gen_seq(7'h7F);
        load_seed(7'h7F);
        for (int i = 0; i < 130; i++) word(1'b0, 1'b0, 64'h0);
        idle(2);
        chk("t1_inj_total", {48'h0, inj_total}, 64'h0);

        // Zero seed behaves as seed 01.
        gen_seq(7'h01);
        load_seed(7'h00);
        for (int i = 0; i < 20; i++) word(1'b0, 1'b0, 64'h0);

        // Full mask then byte-interleaved mask.
        user_data = 8'hA5;
        mask      = 16'hFFFF;
        for (int i = 0; i < 4; i++) word(1'b0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5);
        mask = 16'h00FF;
        for (int i = 0; i < 4; i++) word(1'b0, 1'b0, 64'h0);
        mask = 16'h0000;

        // Periodic: one injection every 10 words, starting on the first word after entry.
        inj_pattern = 64'h1;
        inj_period  = 16'd9;
        inj_mode    = 2'd2;
        word(1'b0, 1'b0, 64'h0);
        word(1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 100; i++) word((i % 10) == 0, 1'b0, 64'h0);
        inj_mode = 2'd0;
        idle(2);
        chk("t4_inj_total", {48'h0, inj_total}, 64'd10);

        do_reset("t5_pre");
        gen_seq(7'h7F);

        // Burst of 3 with a second trigger edge landing mid-burst.
        inj_pattern = '1;
        inj_burst   = 16'd2;
        inj_mode    = 2'd3;
        word(1'b0, 1'b0, 64'h0);
        inj_trig = 1'b1; word(1'b0, 1'b0, 64'h0);
        inj_trig = 1'b0; word(1'b1, 1'b0, 64'h0);
        inj_trig = 1'b1; word(1'b1, 1'b0, 64'h0);
        inj_trig = 1'b0; word(1'b1, 1'b0, 64'h0);
        for (int i = 0; i < 4; i++) word(1'b0, 1'b0, 64'h0);
        idle(2);
        chk("t5_inj_total", {48'h0, inj_total}, 64'd3);

        // Reset in the middle of a running burst.
        inj_trig = 1'b1; word(1'b0, 1'b0, 64'h0);
        inj_trig = 1'b0; word(1'b1, 1'b0, 64'h0);
        word(1'b1, 1'b0, 64'h0);
        do_reset("t6_mid_burst");
        gen_seq(7'h7F);
        for (int i = 0; i < 5; i++) word(1'b0, 1'b0, 64'h0);
        idle(3);
        chk("t6_inj_total", {48'h0, inj_total}, 64'd0);

        chk("drain_queue", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
